// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared register-file constants for the CPU datapath blocks.
//   NUM_REGS           - number of architectural registers
//   REG_SEL_W          - width of a register select
//   DEFAULT_DATA_WIDTH - default datapath width
package cpu_pkg;

    localparam int NUM_REGS           = 4;
    localparam int REG_SEL_W          = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;

endpackage

// File: rtl/wb_queue.sv
// wb_queue
// Circular result queue holding {dest, data} entries waiting for the
// register-file write port.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   push_i         - enqueue {push_dest_i, push_data_i} at the tail
//   pop_i          - retire the head entry
//   head_dest_o/head_data_o - head entry contents
//   count_o        - number of occupied entries
//   occ_o          - per-slot occupied flag
//   dest_flat_o    - per-slot destination, slot i at [i*REG_SEL_W +: REG_SEL_W]
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 2,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [REG_SEL_W-1:0]       push_dest_i,
    input  logic [DATA_WIDTH-1:0]      push_data_i,
    output logic [REG_SEL_W-1:0]       head_dest_o,
    output logic [DATA_WIDTH-1:0]      head_data_o,
    output logic [PTR_W:0]             count_o,
    output logic [DEPTH-1:0]           occ_o,
    output logic [DEPTH*REG_SEL_W-1:0] dest_flat_o
);

    logic [REG_SEL_W-1:0]  dest_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                dest_q[wr_ptr_q] <= push_dest_i;
                data_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        occ_o       = '0;
        dest_flat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off = PTR_W'(i) - rd_ptr_q;
            occ_o[i] = ({1'b0, off} < count_q);
            dest_flat_o[i*REG_SEL_W +: REG_SEL_W] = dest_q[i];
        end
    end

    assign head_dest_o = dest_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
// Buffers completed results and writes them to the register file in
// acceptance order, reporting read-after-write hazards for decode.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   in_valid/in_ready      - result handshake
//   in_wr, in_dest, in_data - result: write enable, destination, value
//   wb_hold                - register file cannot take a write this cycle
//   wb_we, wb_no_write, wb_data - register-file write port
//   rd_sel_1/2, hazard_1/2 - decode read selects and their pending flags
//   wr_count               - writes issued, wraps modulo 2^16
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wr,
    input  logic [REG_SEL_W-1:0]  in_dest,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  wb_hold,
    output logic [REG_SEL_W-1:0]  wb_we,
    output logic                  wb_no_write,
    output logic [DATA_WIDTH-1:0] wb_data,
    input  logic [REG_SEL_W-1:0]  rd_sel_1,
    input  logic [REG_SEL_W-1:0]  rd_sel_2,
    output logic                  hazard_1,
    output logic                  hazard_2,
    output logic [15:0]           wr_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic                       push;
    logic                       pop;
    logic [REG_SEL_W-1:0]       head_dest;
    logic [DATA_WIDTH-1:0]      head_data;
    logic [PTR_W:0]             count;
    logic [DEPTH-1:0]           occ;
    logic [DEPTH*REG_SEL_W-1:0] dest_flat;
    logic [NUM_REGS-1:0]        pending;
    logic [15:0]                wr_count_q, wr_count_d;

    wb_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_dest_i (in_dest),
        .push_data_i (in_data),
        .head_dest_o (head_dest),
        .head_data_o (head_data),
        .count_o     (count),
        .occ_o       (occ),
        .dest_flat_o (dest_flat)
    );

    // Ready depends on registered occupancy only, so upstream never sees
    // a combinational path from wb_hold or in_valid.
    assign in_ready = (count < DEPTH_C);

    // Accepted results with in_wr=0 are simply not enqueued.
    assign push = in_valid & in_ready & in_wr;

    assign wb_no_write = (count == '0) | wb_hold;
    assign pop         = ~wb_no_write;
    assign wb_we       = pop ? head_dest : '0;
    assign wb_data     = pop ? head_data : '0;

    // The head entry stays occupied through its retiring cycle, so it is
    // still reported as pending.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i]) pending[dest_flat[i*REG_SEL_W +: REG_SEL_W]] = 1'b1;
        end
    end

    assign hazard_1 = pending[rd_sel_1];
    assign hazard_2 = pending[rd_sel_2];

    always_comb begin
        wr_count_d = wr_count_q;
        if (pop) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_count_q <= '0;
        else      wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_wr;
    logic [1:0]    in_dest;
    logic [DW-1:0] in_data;
    logic          wb_hold;
    logic [1:0]    wb_we;
    logic          wb_no_write;
    logic [DW-1:0] wb_data;
    logic [1:0]    rd_sel_1;
    logic [1:0]    rd_sel_2;
    logic          hazard_1;
    logic          hazard_2;
    logic [15:0]   wr_count;

    writeback_stage #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wr       (in_wr),
        .in_dest     (in_dest),
        .in_data     (in_data),
        .wb_hold     (wb_hold),
        .wb_we       (wb_we),
        .wb_no_write (wb_no_write),
        .wb_data     (wb_data),
        .rd_sel_1    (rd_sel_1),
        .rd_sel_2    (rd_sel_2),
        .hazard_1    (hazard_1),
        .hazard_2    (hazard_2),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of {dest, data} awaiting write, plus write tally.
    logic [9:0]  mq [$];
    logic [15:0] exp_wrc;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic pend(input logic [1:0] r);
        foreach (mq[i]) if (mq[i][9:8] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_check(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_no_write"}, wb_no_write, 1);
        chk({tag, "_wb_we"}, wb_we, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_hazard_1"}, hazard_1, 0);
        chk({tag, "_hazard_2"}, hazard_2, 0);
        chk({tag, "_wr_count"}, wr_count, 0);
    endtask

    // Called at a falling edge: drive, check against model, clock, update model.
    task automatic step(input logic v, input logic w, input logic [1:0] d,
                        input logic [7:0] dat, input logic h,
                        input logic [1:0] r1, input logic [1:0] r2);
        logic exp_ready, exp_pop;
        in_valid = v; in_wr = w; in_dest = d; in_data = dat;
        wb_hold = h; rd_sel_1 = r1; rd_sel_2 = r2;
        #1;
        exp_ready = (mq.size() < DEPTH);
        exp_pop   = (mq.size() != 0) && !h;
        chk("in_ready", in_ready, exp_ready);
        chk("wb_no_write", wb_no_write, !exp_pop);
        chk("wb_we", wb_we, exp_pop ? mq[0][9:8] : 2'd0);
        chk("wb_data", wb_data, exp_pop ? mq[0][7:0] : 8'd0);
        chk("hazard_1", hazard_1, pend(r1));
        chk("hazard_2", hazard_2, pend(r2));
        chk("wr_count", wr_count, exp_wrc);
        @(posedge clk);
        if (exp_pop) begin
            void'(mq.pop_front());
            exp_wrc++;
        end
        if (v && exp_ready && w) mq.push_back({d, dat});
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 2'd1);
    endtask

    initial begin
        int guard;
        logic [31:0] r;
        rst = 1'b0;
        in_valid = 0; in_wr = 0; in_dest = 0; in_data = 0;
        wb_hold = 0; rd_sel_1 = 0; rd_sel_2 = 0;
        mq.delete();
        exp_wrc = 0;
        repeat (2) @(negedge clk);
        #1 reset_check("por");
        @(negedge clk);
        rst = 1'b1;

        // Single push, dest=2 data=0x5A, presented next cycle.
        step(1'b1, 1'b1, 2'd2, 8'h5A, 1'b0, 2'd2, 2'd0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd0);
        idle();

        // Hold, push dest=1 then dest=3 to fill, then release.
        step(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 2'd1, 2'd3);
        step(1'b1, 1'b1, 2'd3, 8'h33, 1'b1, 2'd1, 2'd3);
        step(1'b1, 1'b1, 2'd0, 8'hEE, 1'b1, 2'd1, 2'd3);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd3);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd3);
        idle();

        // in_wr=0 result is dropped.
        step(1'b1, 1'b0, 2'd1, 8'hFF, 1'b0, 2'd1, 2'd0);
        idle();

        // Back-to-back stream of 8 writes.
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            step(1'b1, 1'b1, r[1:0], r[15:8], 1'b0, r[17:16], r[19:18]);
        end
        repeat (2) idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            step(r[0] | r[1], r[2] | r[3], r[5:4], r[15:8], r[6] & r[7],
                 r[17:16], r[19:18]);
        end
        repeat (3) idle();

        // Fill with two dest=0 entries, then reset asynchronously mid-cycle.
        step(1'b1, 1'b1, 2'd0, 8'hA1, 1'b1, 2'd0, 2'd0);
        step(1'b1, 1'b1, 2'd0, 8'hA2, 1'b1, 2'd0, 2'd0);
        in_valid = 0; wb_hold = 0; rd_sel_1 = 0; rd_sel_2 = 0;
        chk("full_hazard", hazard_1, 1);
        #2 rst = 1'b0;
        #1 reset_check("mid_rst");
        mq.delete();
        exp_wrc = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) idle();

        // Drive wr_count to 0xFFFF, then one more write wraps it.
        guard = 0;
        while ((int'(exp_wrc) + mq.size() < 65535) && guard < 70000) begin
            r = $urandom;
            step(1'b1, 1'b1, r[1:0], r[15:8], 1'b0, r[17:16], r[19:18]);
            guard++;
        end
        while (mq.size() != 0 && guard < 70010) begin
            idle();
            guard++;
        end
        chk("wrc_preset", wr_count, 16'hFFFF);
        step(1'b1, 1'b1, 2'd3, 8'h77, 1'b0, 2'd3, 2'd0);
        idle();
        idle();
        chk("wrc_wrap", wr_count, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of result data and register-file write data.
REQ-002 Parameter DEPTH, default 2, number of result-queue entries; legal values 2 or 4.
REQ-003 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-low reset (0 = reset), clears all state immediately.
REQ-005 Port: in_valid, input, 1, a result is offered this cycle.
REQ-006 Port: in_ready, output, 1, the result queue can accept this cycle.
REQ-007 Port: in_wr, input, 1, 1 = result targets a register; 0 = no register write.
REQ-008 Port: in_dest, input, 2, destination register select.
REQ-009 Port: in_data, input, DATA_WIDTH, result value.
REQ-010 Port: wb_hold, input, 1, register file cannot take a write this cycle.
REQ-011 Port: wb_we, output, 2, register-file write select.
REQ-012 Port: wb_no_write, output, 1, 1 = suppress register-file write.
REQ-013 Port: wb_data, output, DATA_WIDTH, register-file write data.
REQ-014 Port: rd_sel_1 / rd_sel_2, input, 2 each, decode read selects for hazard check.
REQ-015 Port: hazard_1 / hazard_2, output, 1 each, selected register has a queued write.
REQ-016 Port: wr_count, output, 16, number of register writes issued; wraps modulo 2^16.

Function
REQ-017 Handshake: an input is accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 iff the occupancy count < DEPTH, decoded from registered count only, with no combinational path from wb_hold or in_valid.
REQ-019 Accepted inputs with in_wr=0 SHALL be dropped, not enqueued, with no other state change.
REQ-020 Accepted inputs with in_wr=1 SHALL be enqueued at the tail as {dest, data}; the write pointer advances modulo DEPTH.
REQ-021 The head entry SHALL drive wb_we=dest, wb_data=data, and wb_no_write=0 whenever the queue is non-empty and wb_hold=0.
REQ-022 When the queue is empty or wb_hold=1, wb_no_write SHALL be 1, wb_we SHALL be 0, and wb_data SHALL be 0.
REQ-023 Pop occurs on an edge where wb_no_write=0; the read pointer advances modulo DEPTH and wr_count increments by 1.
REQ-024 Latency: an entry accepted at edge k into an empty queue SHALL be presented in the cycle after edge k and retired at edge k+1 if wb_hold=0.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-026 A push while full cannot occur because in_ready=0; in_valid is ignored.
REQ-027 A pop while empty cannot occur; wb_hold while empty has no effect.
REQ-028 Throughput: one write per cycle sustained while wb_hold=0.
REQ-029 pending[r] SHALL be 1 iff any occupied entry has dest=r.
REQ-030 hazard_n SHALL equal pending[rd_sel_n], combinationally.
REQ-031 An entry retiring this cycle still counts as pending in that cycle.
REQ-032 Duplicate destinations SHALL retire strictly in acceptance order.

Reset
REQ-033 When rst=0, the following SHALL be cleared asynchronously: pointers, count, entries, and wr_count. Outputs then read in_ready=1, wb_no_write=1, wb_we=0, wb_data=0, hazard_1=hazard_2=0, and wr_count=0.
REQ-034 Reset mid-operation SHALL discard all queued entries without issuing writes.
REQ-035 The first acceptance SHALL be possible on the first rising edge after rst returns to 1.

Structure
REQ-036 The shared package cpu_pkg SHALL hold NUM_REGS=4, REG_SEL_W=2, and the default DATA_WIDTH=8.
REQ-037 Queue storage and pointers SHALL be one sub-module, wb_queue. Handshake, pending decode, and wr_count SHALL reside in writeback_stage.

Verification
REQ-038 Reset, then a single push of dest=2, data=0x5A -> the next cycle shows wb_we=2, wb_data=0x5A, wb_no_write=0; wr_count=1 after that edge.
REQ-039 Hold wb_hold=1 and push dest=1 then dest=3 -> in_ready=0 after the second push, hazard for 1 and 3 =1; release hold -> writes 1 then 3 on consecutive cycles, then in_ready=1.
REQ-040 Push in_wr=0, data=0xFF -> no write, count stays 0, wr_count unchanged.
REQ-041 Continuous stream of 8 pushes with wb_hold=0 -> 8 writes in order, one per cycle, and wr_count=8.
REQ-042 Queue full with dest=0 and dest=0, then assert rst=0 asynchronously mid-cycle -> outputs immediately at reset values and no write issued.
REQ-043 Preset wr_count to 0xFFFF via 65535 writes, then one more write -> wr_count=0x0000.
